// File: rtl/sram_pkg.sv
// Shared geometry and FSM state type for the SRAM bank controller.
package sram_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } state_e;

endpackage

// File: rtl/sram_addr_dec.sv
// Row address to one-hot word-line decode.
// The output is all zeros when the decoder is not enabled.
module sram_addr_dec #(
  parameter int unsigned ADDR_W = sram_pkg::ADDR_W,
  parameter int unsigned DEPTH  = sram_pkg::DEPTH
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DEPTH-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Two-port request front end for a 2-port SRAM bank.
// Pairs of reads are merged into one access; any write serializes port A then port B.
module sram_bank_ctrl #(
  parameter int unsigned ADDR_W = sram_pkg::ADDR_W,
  parameter int unsigned DATA_W = sram_pkg::DATA_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              srclkpos,
  input  logic              srrstneg,
  input  logic              reqA_valid,
  input  logic              reqA_we,
  input  logic [ADDR_W-1:0] reqA_addr,
  input  logic [DATA_W-1:0] reqA_wdata,
  input  logic              reqB_valid,
  input  logic              reqB_we,
  input  logic [ADDR_W-1:0] reqB_addr,
  input  logic [DATA_W-1:0] reqB_wdata,
  output logic              req_ready,
  output logic [DEPTH-1:0]  wordA,
  output logic [DEPTH-1:0]  wordB,
  output logic              ReadEn,
  output logic              WriteEn,
  output logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] outA,
  input  logic [DATA_W-1:0] outB,
  output logic [DATA_W-1:0] rdataA,
  output logic [DATA_W-1:0] rdataB,
  output logic              rvalidA,
  output logic              rvalidB,
  output logic              wackA,
  output logic              wackB
);

  sram_pkg::state_e r_state, w_state_nxt;

  logic              r_live;
  logic              r_cur_we, r_cur_a, r_cur_b;
  logic [ADDR_W-1:0] r_cur_addr_a, r_cur_addr_b;
  logic [DATA_W-1:0] r_cur_wdata;
  logic              r_pend, r_pend_we;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_wdata;
  logic [DATA_W-1:0] r_rdata_a, r_rdata_b;
  logic              r_rvalid_a, r_rvalid_b, r_wack_a, r_wack_b;
  logic              w_acc_a, w_acc_b, w_drive;

  // r_live keeps req_ready low until the first edge after reset release
  assign req_ready = r_live && (r_state == sram_pkg::IDLE);
  assign w_acc_a   = req_ready & reqA_valid;
  assign w_acc_b   = req_ready & reqB_valid;
  assign w_drive   = (r_state == sram_pkg::DRIVE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      sram_pkg::IDLE:  if (w_acc_a || w_acc_b) w_state_nxt = sram_pkg::DRIVE;
      sram_pkg::DRIVE: w_state_nxt = sram_pkg::RESP;
      sram_pkg::RESP:  w_state_nxt = r_pend ? sram_pkg::DRIVE : sram_pkg::IDLE;
      default:         w_state_nxt = sram_pkg::IDLE;
    endcase
  end

  always_ff @(posedge srclkpos or negedge srrstneg) begin
    if (!srrstneg) begin
      r_state <= sram_pkg::IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  // Single-port and write ops carry the same address on both word lines
  always_ff @(posedge srclkpos or negedge srrstneg) begin
    if (!srrstneg) begin
      r_cur_we     <= 1'b0;
      r_cur_a      <= 1'b0;
      r_cur_b      <= 1'b0;
      r_cur_addr_a <= '0;
      r_cur_addr_b <= '0;
      r_cur_wdata  <= '0;
      r_pend       <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
    end else if (r_state == sram_pkg::IDLE && (w_acc_a || w_acc_b)) begin
      if (w_acc_a && w_acc_b && !reqA_we && !reqB_we) begin
        r_cur_we     <= 1'b0;
        r_cur_a      <= 1'b1;
        r_cur_b      <= 1'b1;
        r_cur_addr_a <= reqA_addr;
        r_cur_addr_b <= reqB_addr;
        r_cur_wdata  <= reqA_wdata;
        r_pend       <= 1'b0;
      end else if (w_acc_a) begin
        r_cur_we     <= reqA_we;
        r_cur_a      <= 1'b1;
        r_cur_b      <= 1'b0;
        r_cur_addr_a <= reqA_addr;
        r_cur_addr_b <= reqA_addr;
        r_cur_wdata  <= reqA_wdata;
        r_pend       <= w_acc_b;
        r_pend_we    <= reqB_we;
        r_pend_addr  <= reqB_addr;
        r_pend_wdata <= reqB_wdata;
      end else begin
        r_cur_we     <= reqB_we;
        r_cur_a      <= 1'b0;
        r_cur_b      <= 1'b1;
        r_cur_addr_a <= reqB_addr;
        r_cur_addr_b <= reqB_addr;
        r_cur_wdata  <= reqB_wdata;
        r_pend       <= 1'b0;
      end
    end else if (r_state == sram_pkg::RESP && r_pend) begin
      r_cur_we     <= r_pend_we;
      r_cur_a      <= 1'b0;
      r_cur_b      <= 1'b1;
      r_cur_addr_a <= r_pend_addr;
      r_cur_addr_b <= r_pend_addr;
      r_cur_wdata  <= r_pend_wdata;
      r_pend       <= 1'b0;
    end
  end

  always_ff @(posedge srclkpos or negedge srrstneg) begin
    if (!srrstneg) begin
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_wack_a   <= 1'b0;
      r_wack_b   <= 1'b0;
    end else begin
      r_rvalid_a <= w_drive & r_cur_a & ~r_cur_we;
      r_rvalid_b <= w_drive & r_cur_b & ~r_cur_we;
      r_wack_a   <= w_drive & r_cur_a & r_cur_we;
      r_wack_b   <= w_drive & r_cur_b & r_cur_we;
      if (w_drive && r_cur_a && !r_cur_we) r_rdata_a <= outA;
      if (w_drive && r_cur_b && !r_cur_we) r_rdata_b <= outB;
    end
  end

  assign rdataA  = r_rdata_a;
  assign rdataB  = r_rdata_b;
  assign rvalidA = r_rvalid_a;
  assign rvalidB = r_rvalid_b;
  assign wackA   = r_wack_a;
  assign wackB   = r_wack_b;

  assign ReadEn  = w_drive & ~r_cur_we;
  assign WriteEn = w_drive & r_cur_we;
  assign in      = (w_drive && r_cur_we) ? r_cur_wdata : '0;

  sram_addr_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_a (
    .en_i     (w_drive),
    .addr_i   (r_cur_addr_a),
    .onehot_o (wordA)
  );

  sram_addr_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_b (
    .en_i     (w_drive),
    .addr_i   (r_cur_addr_b),
    .onehot_o (wordB)
  );

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl with a behavioural 2-port array model.
module tb_sram_bank_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned DP = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          a_valid, a_we, b_valid, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          req_ready, read_en, write_en;
  logic [DP-1:0] word_a, word_b;
  logic [DW-1:0] array_in, out_a, out_b, rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b, wack_a, wack_b;
  logic [DW-1:0] mem [DP];
  logic          mem_init = 1'b1;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  sram_bank_ctrl dut (
    .srclkpos   (clk),
    .srrstneg   (rstn),
    .reqA_valid (a_valid),
    .reqA_we    (a_we),
    .reqA_addr  (a_addr),
    .reqA_wdata (a_wdata),
    .reqB_valid (b_valid),
    .reqB_we    (b_we),
    .reqB_addr  (b_addr),
    .reqB_wdata (b_wdata),
    .req_ready  (req_ready),
    .wordA      (word_a),
    .wordB      (word_b),
    .ReadEn     (read_en),
    .WriteEn    (write_en),
    .in         (array_in),
    .outA       (out_a),
    .outB       (out_b),
    .rdataA     (rdata_a),
    .rdataB     (rdata_b),
    .rvalidA    (rvalid_a),
    .rvalidB    (rvalid_b),
    .wackA      (wack_a),
    .wackB      (wack_b)
  );

  // Array model: rows preset to 0xA000+row, written through word line A
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DP; i++) mem[i] <= DW'(16'hA000 + i);
    end else if (write_en) begin
      for (int i = 0; i < DP; i++) if (word_a[i]) mem[i] <= array_in;
    end
  end

  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int i = 0; i < DP; i++) begin
      if (word_a[i]) out_a = mem[i];
      if (word_b[i]) out_b = mem[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  initial begin
    idle_inputs();
    #2;
    check("rst_ready", req_ready, 0);
    check("rst_wordA", word_a, 0);
    check("rst_writeen", write_en, 0);
    check("rst_readen", read_en, 0);
    check("rst_rdataA", rdata_a, 0);
    tick();
    mem_init = 1'b0;
    check("rst_ready_held", req_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("ready_before_edge", req_ready, 0);
    tick();
    check("ready_after_release", req_ready, 1);

    // Write A addr 3 = 0xBEEF
    a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd3; a_wdata = 16'hBEEF;
    tick();
    idle_inputs();
    check("w3_writeen", write_en, 1);
    check("w3_readen", read_en, 0);
    check("w3_wordA", word_a, 32'h0000_0008);
    check("w3_wordB", word_b, 32'h0000_0008);
    check("w3_in", array_in, 16'hBEEF);
    check("w3_ready_low", req_ready, 0);
    check("w3_no_early_wack", wack_a, 0);
    tick();
    check("w3_writeen_off", write_en, 0);
    check("w3_wordA_off", word_a, 0);
    check("w3_wackA", wack_a, 1);
    check("w3_no_rvalid", rvalid_a, 0);
    check("w3_row3", mem[3], 16'hBEEF);
    check("w3_row0", mem[0], 16'hA000);
    tick();
    check("w3_wack_pulse", wack_a, 0);
    check("w3_ready_back", req_ready, 1);

    // Dual read A addr 3, B addr 31
    a_valid = 1'b1; a_addr = 5'd3;
    b_valid = 1'b1; b_addr = 5'd31;
    tick();
    idle_inputs();
    check("dr_readen", read_en, 1);
    check("dr_writeen", write_en, 0);
    check("dr_wordA", word_a, 32'h0000_0008);
    check("dr_wordB", word_b, 32'h8000_0000);
    check("dr_in", array_in, 0);
    tick();
    check("dr_readen_off", read_en, 0);
    check("dr_rvalidA", rvalid_a, 1);
    check("dr_rvalidB", rvalid_b, 1);
    check("dr_rdataA", rdata_a, 16'hBEEF);
    check("dr_rdataB", rdata_b, 16'hA01F);
    tick();
    check("dr_rvalid_pulse", rvalid_a, 0);
    check("dr_rdataA_hold", rdata_a, 16'hBEEF);
    check("dr_ready_back", req_ready, 1);

    // Write A addr 5 with read B addr 5 on the same edge
    a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd5; a_wdata = 16'h1234;
    b_valid = 1'b1; b_addr = 5'd5;
    tick();
    idle_inputs();
    check("raw_drv1_writeen", write_en, 1);
    check("raw_drv1_wordB", word_b, 32'h0000_0020);
    check("raw_drv1_ready", req_ready, 0);
    tick();
    check("raw_wackA", wack_a, 1);
    check("raw_early_rvalidB", rvalid_b, 0);
    check("raw_resp1_ready", req_ready, 0);
    tick();
    check("raw_drv2_readen", read_en, 1);
    check("raw_drv2_writeen", write_en, 0);
    check("raw_drv2_wordA", word_a, 32'h0000_0020);
    check("raw_drv2_wordB", word_b, 32'h0000_0020);
    check("raw_drv2_wack_off", wack_a, 0);
    check("raw_drv2_ready", req_ready, 0);
    tick();
    check("raw_rvalidB", rvalid_b, 1);
    check("raw_rdataB", rdata_b, 16'h1234);
    check("raw_resp2_ready", req_ready, 0);
    tick();
    check("raw_ready_back", req_ready, 1);
    check("raw_rvalid_pulse", rvalid_b, 0);

    // Two writes to addr 7: B lands last
    a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd7; a_wdata = 16'hAAAA;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd7; b_wdata = 16'h5555;
    tick();
    idle_inputs();
    check("ww_in_a", array_in, 16'hAAAA);
    check("ww_wordA_a", word_a, 32'h0000_0080);
    tick();
    check("ww_wackA", wack_a, 1);
    check("ww_no_wackB", wack_b, 0);
    tick();
    check("ww_writeen_b", write_en, 1);
    check("ww_in_b", array_in, 16'h5555);
    check("ww_wordB_b", word_b, 32'h0000_0080);
    tick();
    check("ww_wackB", wack_b, 1);
    check("ww_wackA_off", wack_a, 0);
    tick();
    check("ww_ready_back", req_ready, 1);
    a_valid = 1'b1; a_addr = 5'd7;
    tick();
    idle_inputs();
    check("ww_rd_readen", read_en, 1);
    check("ww_rd_wordB_mirror", word_b, 32'h0000_0080);
    tick();
    check("ww_rd_rvalidA", rvalid_a, 1);
    check("ww_rd_rdataA", rdata_a, 16'h5555);
    check("ww_rd_no_rvalidB", rvalid_b, 0);
    check("ww_rd_rdataB_hold", rdata_b, 16'h1234);
    tick();

    // Reset during the pending B write's DRIVE
    a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd9;  a_wdata = 16'h1111;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd10; b_wdata = 16'h2222;
    tick();
    idle_inputs();
    tick();
    tick();
    check("rm_pend_writeen", write_en, 1);
    check("rm_pend_in", array_in, 16'h2222);
    check("rm_pend_wordA", word_a, 32'h0000_0400);
    #2;
    rstn = 1'b0;
    #1;
    check("rm_writeen", write_en, 0);
    check("rm_wordA", word_a, 0);
    check("rm_wordB", word_b, 0);
    check("rm_in", array_in, 0);
    check("rm_ready", req_ready, 0);
    check("rm_rdataA", rdata_a, 0);
    check("rm_rdataB", rdata_b, 0);
    tick();
    check("rm_no_wackB", wack_b, 0);
    check("rm_ready_in_reset", req_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rm_ready_pre_edge", req_ready, 0);
    tick();
    check("rm_ready_after", req_ready, 1);
    check("rm_no_wackB_after", wack_b, 0);
    check("rm_no_writeen", write_en, 0);
    tick();
    check("rm_pend_dropped", write_en, 0);
    check("rm_still_ready", req_ready, 1);

    // Single read on port B mirrors its word line onto A
    b_valid = 1'b1; b_addr = 5'd3;
    tick();
    idle_inputs();
    check("rb_readen", read_en, 1);
    check("rb_wordA_mirror", word_a, 32'h0000_0008);
    tick();
    check("rb_rvalidB", rvalid_b, 1);
    check("rb_no_rvalidA", rvalid_a, 0);
    check("rb_rdataB", rdata_b, 16'hBEEF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bank_ctrl.md
SRAM_BANK_CTRL -- requirements
Module: sram_bank_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, word address width.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter DEPTH, default 32, number of rows (2**ADDR_W).
REQ-004 srclkpos  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 srrstneg  in  1  reset, asynchronous, active-low.
REQ-006 reqA_valid / reqB_valid  in  1  port request valid.
REQ-007 reqA_we / reqB_we  in  1  1 = write, 0 = read.
REQ-008 reqA_addr / reqB_addr  in  ADDR_W  row address.
REQ-009 reqA_wdata / reqB_wdata  in  DATA_W  write data.
REQ-010 req_ready  out  1  both ports accepted when high.
REQ-011 wordA / wordB  out  DEPTH  one-hot row selects to the array.
REQ-012 ReadEn / WriteEn  out  1  array strobes.
REQ-013 in  out  DATA_W  array write data.
REQ-014 outA / outB  in  DATA_W  array read data.
REQ-015 rdataA / rdataB  out  DATA_W  registered read data.
REQ-016 rvalidA / rvalidB, wackA / wackB  out  1  one-cycle read-valid / write-ack pulses.

Function
REQ-017 States SHALL be IDLE, DRIVE, RESP; req_ready SHALL be high only in IDLE.
REQ-018 A port is accepted on an edge where req_ready and its valid are high; both ports may be accepted on the same edge.
REQ-019 Two reads accepted together SHALL form one operation: wordA = onehot(addrA), wordB = onehot(addrB), ReadEn = 1 for the single DRIVE cycle.
REQ-020 Any accepted write SHALL be serialized: port A's operation first, port B's held in a pending register and executed on the following DRIVE.
REQ-021 Write DRIVE SHALL drive WriteEn = 1, ReadEn = 0, in = wdata, and wordA = wordB = onehot(addr); a zero word line is never permitted during WriteEn, to avoid a stray write to row 0.
REQ-022 Read DRIVE on a single port SHALL drive the unused word line equal to the used one.
REQ-023 Outside DRIVE, wordA, wordB, ReadEn, WriteEn and in SHALL be 0.
REQ-024 On the DRIVE->RESP edge: read data SHALL be captured from outA/outB into rdataA/rdataB, and the matching rvalid/wack SHALL be high for exactly the RESP cycle.
REQ-025 Latency: response pulse 2 edges after acceptance; a pending B response follows 2 edges after A's.
REQ-026 RESP SHALL go to DRIVE if pending, otherwise to IDLE; rdataA/rdataB SHALL hold between reads.
REQ-027 Read-after-write to the same address on the same port pair SHALL return the new data (A write then B read sees A's data).
REQ-028 Two writes to the same address SHALL leave B's data in the row.
REQ-029 Address values >= DEPTH are not possible (DEPTH = 2**ADDR_W); no error path.

Reset
REQ-030 srrstneg low SHALL immediately force state IDLE, clear pending, and drive all outputs 0 except req_ready = 0.
REQ-031 req_ready SHALL become 1 on the first rising edge after srrstneg deasserts.
REQ-032 Reset mid-operation SHALL drop in-flight and pending requests with no response pulse; array contents are unspecified.

Structure
REQ-033 Package sram_pkg SHALL hold ADDR_W, DATA_W, DEPTH and the state enum type.
REQ-034 Address-to-one-hot decode SHALL be a sub-module sram_addr_dec, instantiated twice.
REQ-035 sram_bank_ctrl SHALL connect directly to the 2-port array's port list, with no glue logic.

Verification
REQ-036 Write A addr 3 data 0xBEEF -> WriteEn for one cycle with wordA = wordB = 0x00000008, wackA 2 edges later; row 0 is unchanged.
REQ-037 Dual read, A addr 3, B addr 31, after REQ-036 -> single DRIVE, rdataA = 0xBEEF, rdataB = row 31, rvalidA and rvalidB in the same cycle.
REQ-038 Write A addr 5 = 0x1234 and read B addr 5 in the same edge -> wackA, then rvalidB 2 edges later with 0x1234; req_ready low for 4 cycles.
REQ-039 Writes A addr 7 = 0xAAAA and B addr 7 = 0x5555 together -> subsequent read of addr 7 returns 0x5555.
REQ-040 Assert srrstneg during DRIVE of a pending pair -> outputs 0 immediately, no pulses, req_ready = 1 one edge after release.
